// File: rtl/aes_enc_arbiter.sv
// Round-robin front end that shares one fixed-latency aes_enc core between NUM_REQ requesters.
// One job is in flight at a time. The result is held in a response register until the consumer takes it.
module aes_enc_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int CORE_LAT = 11,
    parameter int CNT_W    = $clog2(CORE_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*128-1:0] req_data_i,
    input  logic [NUM_REQ*128-1:0] req_key_i,
    output logic                   core_data_v_o,
    output logic [127:0]           core_data_o,
    output logic [127:0]           core_key_o,
    input  logic [127:0]           core_res_i,
    input  logic                   core_res_v_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [127:0]           rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic                   rsp_err_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ID_W-1:0]   rr_last_q;
    logic [ID_W-1:0]   job_id_q;
    logic              rsp_valid_q;
    logic [127:0]      rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_err_q;
    logic              err_q;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic              grant_d;
    logic              grant_out;
    logic              res_expected;

    // Both request and response sides use valid/ready. A transfer happens on a rising edge where
    // valid and ready are both high. The source holds valid and its payload stable until that edge.

    // The upper pass (indices above rr_last) runs second, so its lowest hit overrides the wrapped pass.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i <= int'(rr_last_q))) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i > int'(rr_last_q))) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    assign grant_d      = (state_q == IDLE) && win_found;
    assign cnt_d        = cnt_q + CNT_W'(1);
    assign res_expected = (state_q == RUN) && (cnt_q == CNT_W'(CORE_LAT));

    // The grant is combinational, so it is masked while reset is asserted to keep outputs quiet.
    assign grant_out = grant_d && nreset;

    always_comb begin
        req_ready_o = '0;
        core_data_o = '0;
        core_key_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_out && (win_idx == ID_W'(i))) begin
                req_ready_o[i] = 1'b1;
                core_data_o    = req_data_i[i*128 +: 128];
                core_key_o     = req_key_i[i*128 +: 128];
            end
        end
    end

    assign core_data_v_o = grant_out;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_last_q   <= ID_W'(NUM_REQ - 1);
            job_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Any result strobe outside the single expected cycle is a core timing fault.
            if (core_res_v_i && !res_expected) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        rr_last_q <= win_idx;
                        job_id_q  <= win_idx;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (res_expected) begin
                        rsp_data_q  <= core_res_i;
                        rsp_id_q    <= job_id_q;
                        rsp_err_q   <= ~core_res_v_i;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Bench for aes_enc_arbiter. A stub core drives the result side, and a cycle-timed transaction model
// predicts grants, responses and error flags.
module tb_aes_enc_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int CORE_LAT = 11;
    localparam int W        = 128;

    logic                   clk = 1'b0;
    logic                   nreset;
    logic [NUM_REQ-1:0]     req_valid_i;
    logic [NUM_REQ-1:0]     req_ready_o;
    logic [NUM_REQ*128-1:0] req_data_i;
    logic [NUM_REQ*128-1:0] req_key_i;
    logic                   core_data_v_o;
    logic [127:0]           core_data_o;
    logic [127:0]           core_key_o;
    logic [127:0]           core_res_i;
    logic                   core_res_v_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [127:0]           rsp_data_o;
    logic [ID_W-1:0]        rsp_id_o;
    logic                   rsp_err_o;
    logic                   err_o;

    always #5 clk = ~clk;

    aes_enc_arbiter #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_key_i(req_key_i),
        .core_data_v_o(core_data_v_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
        .core_res_i(core_res_i), .core_res_v_i(core_res_v_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .err_o(err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] core_fn(input logic [W-1:0] d, input logic [W-1:0] k);
        return ({d[63:0], d[127:64]} ^ k) + 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Requester-side state and the stimulus policies.
    bit             rv[NUM_REQ];
    logic [W-1:0]   rd[NUM_REQ];
    logic [W-1:0]   rk[NUM_REQ];
    int             pol_req = 0;
    int             pol_rdy = 0;
    int             last_gnt = -1;
    int             cyc = 0;
    bit             rel_pending = 0;

    // Stub core state.
    bit             st_act = 0;
    int             st_start = 0;
    logic [W-1:0]   st_res;
    bit             st_fault = 0;
    bit             fault_next = 0;
    bit             spur = 0;

    // Reference model: job timing and the scoreboard.
    int             m_rr = NUM_REQ - 1;
    bit             m_busy = 0;
    int             m_g = 0;
    int             m_id = 0;
    int             m_free = 0;
    bit             m_err = 0;
    bit             m_rsp_err = 0;
    logic [W-1:0]   exp_q[$];
    int             g_id_q[$];
    int             g_cyc_q[$];
    int             rsp_log[$];

    task automatic pack();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid_i[k]          = rv[k];
            req_data_i[k*128 +: 128] = rd[k];
            req_key_i[k*128 +: 128]  = rk[k];
        end
    endtask

    task automatic model_check();
        int win;
        logic [NUM_REQ-1:0] exp_rdy;
        bit exp_rv;
        win = -1;
        if (nreset && !m_busy && cyc >= m_free) begin
            for (int o = 1; o <= NUM_REQ; o++) begin
                int idx;
                idx = (m_rr + o) % NUM_REQ;
                if (win < 0 && rv[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", req_ready_o, exp_rdy);
        chk("core_data_v", core_data_v_o, win >= 0);
        chk("core_data", core_data_o, (win >= 0) ? rd[win] : '0);
        chk("core_key", core_key_o, (win >= 0) ? rk[win] : '0);
        exp_rv = m_busy && (cyc >= m_g + CORE_LAT + 1);
        chk("rsp_valid", rsp_valid_o, exp_rv);
        if (exp_rv) begin
            chk("rsp_data", rsp_data_o, (exp_q.size() > 0) ? exp_q[0] : '0);
            chk("rsp_id", rsp_id_o, m_id);
            chk("rsp_err", rsp_err_o, m_rsp_err);
        end
        chk("err", err_o, m_err);

        // Drive-side bookkeeping follows the DUT's actual handshakes, as a real core and requester would.
        last_gnt = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_o[k] && rv[k]) last_gnt = k;
        end
        if (last_gnt >= 0) begin
            g_id_q.push_back(last_gnt);
            g_cyc_q.push_back(cyc);
        end
        if (core_data_v_o) begin
            st_act     = 1;
            st_start   = cyc;
            st_res     = core_fn(core_data_o, core_key_o);
            st_fault   = fault_next;
            fault_next = 0;
        end

        if (core_res_v_i && !(m_busy && cyc == m_g + CORE_LAT)) m_err = 1;
        if (m_busy && cyc == m_g + CORE_LAT) m_rsp_err = !core_res_v_i;
        if (exp_rv && rsp_ready_i) begin
            m_busy = 0;
            m_free = cyc + 1;
            rsp_log.push_back(int'(rsp_id_o));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (win >= 0) begin
            m_busy = 1;
            m_g    = cyc;
            m_id   = win;
            m_rr   = win;
            exp_q.push_back(core_fn(rd[win], rk[win]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rel_pending) begin
            nreset      = 1'b1;
            rel_pending = 0;
        end
        if (last_gnt >= 0) rv[last_gnt] = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pol_req == 1 && !rv[k]) begin
                rv[k] = 1; rd[k] = rnd128(); rk[k] = rnd128();
            end else if (pol_req == 2) begin
                if (!rv[k] && $urandom_range(0, 3) == 0) begin
                    rv[k] = 1; rd[k] = rnd128(); rk[k] = rnd128();
                end else if (rv[k] && $urandom_range(0, 15) == 0) begin
                    rv[k] = 0;
                end
            end
        end
        pack();
        case (pol_rdy)
            0: rsp_ready_i = 1'b1;
            1: rsp_ready_i = ($urandom_range(0, 2) != 0);
            default: rsp_ready_i = 1'b0;
        endcase
        core_res_v_i = 1'b0;
        core_res_i   = rnd128();
        if (st_act && st_fault && cyc == st_start + 5) core_res_v_i = 1'b1;
        if (st_act && cyc == st_start + CORE_LAT) begin
            core_res_i   = st_res;
            core_res_v_i = !st_fault;
            st_act       = 0;
        end
        if (spur) begin
            core_res_v_i = 1'b1;
            spur         = 0;
        end
        #1;
        model_check();
        cyc++;
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_core_v", core_data_v_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_id", rsp_id_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_err", err_o, 0);
        m_busy = 0; m_rr = NUM_REQ - 1; m_err = 0; m_free = 0;
        exp_q.delete();
        st_act = 0; fault_next = 0; last_gnt = -1;
        repeat (hold) step();
        rel_pending = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        nreset = 1'b0;
        rsp_ready_i = 1'b1;
        core_res_v_i = 1'b0;
        core_res_i = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rv[k] = 0; rd[k] = '0; rk[k] = '0;
        end
        pack();

        // Single job from requester 1, with known plaintext and key.
        apply_reset(3);
        repeat (5) step();
        rv[1] = 1;
        rd[1] = 128'h00112233445566778899aabbccddeeff;
        rk[1] = 128'h000102030405060708090a0b0c0d0e0f;
        t0 = cyc;
        repeat (20) step();
        chk("single_grant_cnt", g_id_q.size(), 1);
        if (g_id_q.size() >= 1) begin
            chk("single_grant_id", g_id_q[0], 1);
            chk("single_grant_cyc", g_cyc_q[0], t0);
        end
        chk("single_rsp_cnt", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) chk("single_rsp_id", rsp_log[0], 1);

        // Continuous requests from all requesters: rotation and spacing.
        pol_req = 1;
        apply_reset(2);
        g_id_q.delete(); g_cyc_q.delete(); rsp_log.delete();
        repeat (70) step();
        chk("rot_grant_cnt", g_id_q.size() >= 5, 1);
        if (g_id_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rot_order", g_id_q[i], i % NUM_REQ);
            for (int i = 1; i < 5; i++) chk("rot_spacing", g_cyc_q[i] - g_cyc_q[i-1], CORE_LAT + 2);
        end
        chk("rot_rsp_cnt", rsp_log.size() >= 4, 1);
        if (rsp_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rot_rsp_id", rsp_log[i], i);
        end

        // Backpressure, then release.
        pol_rdy = 2;
        repeat (35) step();
        pol_rdy = 0;
        repeat (20) step();

        // Random traffic and random consumer stalls.
        pol_req = 2;
        pol_rdy = 1;
        repeat (300) step();

        // Core fault: the strobe arrives early and is missing at the due cycle.
        pol_req = 0;
        pol_rdy = 0;
        for (int k = 0; k < NUM_REQ; k++) rv[k] = 0;
        repeat (30) step();
        fault_next = 1;
        rv[2] = 1; rd[2] = rnd128(); rk[2] = rnd128();
        repeat (30) step();
        chk("fault_err_sticky", err_o, 1);

        // Reset in the middle of a job.
        rv[3] = 1; rd[3] = rnd128(); rk[3] = rnd128();
        n0 = g_id_q.size();
        for (int i = 0; i < 20 && g_id_q.size() == n0; i++) step();
        chk("midjob_granted", g_id_q.size() > n0, 1);
        repeat (5) step();
        pol_req = 1;
        apply_reset(2);
        g_id_q.delete(); g_cyc_q.delete();
        repeat (3) step();
        chk("post_rst_grant_cnt", g_id_q.size(), 1);
        if (g_id_q.size() >= 1) chk("post_rst_first_id", g_id_q[0], 0);

        // Spurious result strobe while idle.
        pol_req = 0;
        for (int k = 0; k < NUM_REQ; k++) rv[k] = 0;
        repeat (30) step();
        chk("idle_err_clear", err_o, 0);
        spur = 1;
        repeat (10) step();
        chk("idle_spur_err", err_o, 1);
        chk("idle_spur_no_rsp", rsp_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
